// File: rtl/descrambler_1.sv
// Byte-wide self-synchronising descrambler for x^7 + x^4 + 1 with a registered valid/ready output stage.
// Optional output-handshake counter port byte_cnt enabled by DESCRAMBLER_BYTE_CNT_EN.
module descrambler_1 #(
  parameter int unsigned POLY_TAP_A  = 6,
  parameter int unsigned POLY_TAP_B  = 3,
  parameter int unsigned PRIME_BYTES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  data_out,
`ifdef DESCRAMBLER_BYTE_CNT_EN
  output logic [15:0] byte_cnt,
`endif
  output logic        locked
);

  localparam int unsigned STATE_W = 7;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned BCNT_W  = 16;

  typedef enum logic {ST_PRIME, ST_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [STATE_W-1:0]  r_s, w_s_nxt, w_s_adv;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                r_out_valid, w_out_valid_nxt;
  logic [BYTE_W-1:0]   r_data_out, w_data_out_nxt, w_o;
  logic                r_locked, w_locked_nxt;
  logic                w_acc;
  logic                w_out_hs;

  assign in_ready  = ~r_out_valid | out_ready;
  assign w_acc     = in_valid & in_ready;
  assign w_out_hs  = r_out_valid & out_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Bit-serial descramble of one byte, LSB first; only received bits enter the state
  always_comb begin
    w_s_adv = r_s;
    w_o     = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      w_o[i]  = data_in[i] ^ w_s_adv[POLY_TAP_A] ^ w_s_adv[POLY_TAP_B];
      w_s_adv = {w_s_adv[STATE_W-2:0], data_in[i]};
    end
  end

  // Next-state and registered-output logic; flush overrides any concurrent accept
  always_comb begin
    w_state_nxt     = r_state;
    w_s_nxt         = r_s;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_data_out_nxt  = r_data_out;
    w_locked_nxt    = r_locked;
    if (flush) begin
      w_state_nxt     = ST_PRIME;
      w_s_nxt         = '0;
      w_cnt_nxt       = '0;
      w_out_valid_nxt = 1'b0;
      w_locked_nxt    = 1'b0;
    end else begin
      if (w_out_hs) begin
        w_out_valid_nxt = 1'b0;
      end
      case (r_state)
        ST_PRIME: begin
          if (w_acc) begin
            w_s_nxt = w_s_adv;
            if (w_cnt_inc == CNT_W'(PRIME_BYTES)) begin
              w_state_nxt  = ST_RUN;
              w_cnt_nxt    = '0;
              w_locked_nxt = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        ST_RUN: begin
          if (w_acc) begin
            w_s_nxt         = w_s_adv;
            w_data_out_nxt  = w_o;
            w_out_valid_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_PRIME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PRIME;
      r_s         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_data_out  <= w_data_out_nxt;
      r_locked    <= w_locked_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign locked    = r_locked;

`ifdef DESCRAMBLER_BYTE_CNT_EN
  logic [BCNT_W-1:0] r_byte_cnt;

  // Saturating count of output handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
    end else if (flush) begin
      r_byte_cnt <= '0;
    end else if (w_out_hs && (r_byte_cnt != {BCNT_W{1'b1}})) begin
      r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
    end
  end

  assign byte_cnt = r_byte_cnt;
`endif

endmodule

// File: tb/tb_descrambler_1.sv
// Self-checking bench for descrambler_1: scrambler model feeds a scoreboard of expected plaintext.
module tb_descrambler_1;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_out;
  logic        locked;
`ifdef DESCRAMBLER_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  descrambler_1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
`ifdef DESCRAMBLER_BYTE_CNT_EN
    .byte_cnt  (byte_cnt),
`endif
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          tb_hs = 0;
  int          prime_left = 1;
  logic [7:0]  sb[$];
  logic [6:0]  sc_s;

  // Upstream multiplicative scrambler model: c = p ^ s6 ^ s3, scrambled bit enters state
  task automatic scramble(input logic [7:0] p, output logic [7:0] c);
    for (int i = 0; i < 8; i++) begin
      c[i] = p[i] ^ sc_s[6] ^ sc_s[3];
      sc_s = {sc_s[5:0], c[i]};
    end
  endtask

  // Output monitor: handshake seen at negedge completes at the following posedge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tb_hs++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got data_out=0x%02h, scoreboard empty", data_out);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (data_out !== exp) begin
          n_err++;
          $display("FAIL data_out: got 0x%02h expected 0x%02h at %0t", data_out, exp, $time);
        end
      end
    end
  end

  // Present one byte, wait (bounded) for acceptance, leave in_valid high on return
  task automatic send_byte(input logic [7:0] d, input logic [7:0] exp);
    int n = 0;
    in_valid = 1'b1;
    data_in  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end else if (prime_left > 0) begin
      prime_left--;
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_plain(input logic [7:0] p);
    logic [7:0] c;
    scramble(p, c);
    send_byte(c, p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; data_in = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data_out: got 0x%02h expected 0x00", data_out); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %0b expected 0", locked); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL idle_locked: got %0b expected 0", locked); end
    @(posedge clk); #1;
  endtask

  task automatic test_prime_lock();
    prime_left = 1;
    send_byte(8'hFF, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL prime_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL prime_locked: got %0b expected 1", locked); end
    @(posedge clk); #1;
    send_byte(8'h00, 8'h70);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_latency: out_valid=%0b expected 1", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_clear: out_valid=%0b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic reprime();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tb_hs = 0;
    prime_left = 1;
  endtask

  task automatic test_back_to_back();
    time t0;
    reprime();
    sc_s = 7'h5A;
    t0 = $time;
    for (int i = 0; i < 256; i++) send_plain(8'(i));
    n_cmp++;
    if ($time - t0 != 2560) begin
      n_err++;
      $display("FAIL throughput: took %0t expected 2560", $time - t0);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] c2, p2, held;
    send_plain(8'h3C);
    out_ready = 1'b0;
    p2 = 8'hC3;
    scramble(p2, c2);
    data_in = c2;
    @(negedge clk);
    held = data_out;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || data_out !== held) begin
        n_err++; $display("FAIL bp_hold: out_valid=%0b data_out=0x%02h expected 1/0x%02h", out_valid, data_out, held);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_byte(c2, p2);
    send_plain(8'h81);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    send_plain(8'h11);
    flush = 1'b1; in_valid = 1'b1; data_in = 8'hA5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    tb_hs = 0;
    prime_left = 1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL flush_locked: got %0b expected 0", locked); end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send_plain(8'(8'h20 + i * 7));
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_bit_error();
    logic [7:0] p, c, exp;
    for (int i = 0; i < 8; i++) begin
      p = 8'(8'h90 + i);
      scramble(p, c);
      exp = p;
      if (i == 3) begin
        c   = c ^ 8'h04;
        exp = p ^ 8'h44;
      end else if (i == 4) begin
        exp = p ^ 8'h02;
      end
      send_byte(c, exp);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    sc_s = 7'h00;
    test_reset();
    test_prime_lock();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_bit_error();
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL lost_bytes: %0d left in scoreboard, expected 0", sb.size());
    end
`ifdef DESCRAMBLER_BYTE_CNT_EN
    n_cmp++;
    if (byte_cnt !== 16'(tb_hs)) begin
      n_err++;
      $display("FAIL byte_cnt: got %0d expected %0d", byte_cnt, tb_hs);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
